// File: rtl/bsc_reset_pulse_gen_pkg.sv
// Shared types and helpers for the reset pulse generator.
// The holdoff state is only reachable with BSC_RESET_PULSE_GEN_HOLDOFF_EN.
`ifndef BSC_RESET_PULSE_GEN_PKG_SV
`define BSC_RESET_PULSE_GEN_PKG_SV
package bsc_reset_pulse_gen_pkg;

  localparam logic [1:0] ENC_ASSERT  = 2'd0;
  localparam logic [1:0] ENC_HOLDOFF = 2'd1;
  localparam logic [1:0] ENC_IDLE    = 2'd2;

  typedef enum logic [1:0] {
    ST_ASSERT  = ENC_ASSERT,
    ST_HOLDOFF = ENC_HOLDOFF,
    ST_IDLE    = ENC_IDLE
  } state_t;

  function automatic int cnt_width(
    input int a,
    input int h
  );
    int m;
    m = (a > h) ? a : h;
    return $clog2(m + 1);
  endfunction

endpackage
`endif

// File: rtl/bsc_reset_pulse_gen.sv
// Downstream reset pulse generator: fixed-length active-low pulse per event.
// Define BSC_RESET_PULSE_GEN_HOLDOFF_EN to refuse requests after release.
`ifndef BSC_RESET_PULSE_GEN_SV
`define BSC_RESET_PULSE_GEN_SV
module bsc_reset_pulse_gen
  import bsc_reset_pulse_gen_pkg::*;
#(
  parameter int ASSERT_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  output logic resetn_out,
  output logic in_reset,
  output logic done_pulse
);

  localparam int CW = cnt_width(ASSERT_CYCLES, HOLDOFF_CYCLES);
  localparam logic [CW-1:0] A_LOAD = CW'(ASSERT_CYCLES - 1);
`ifdef BSC_RESET_PULSE_GEN_HOLDOFF_EN
  localparam logic [CW-1:0] H_LOAD = CW'(HOLDOFF_CYCLES - 1);
`endif

  state_t        state;
  logic [CW-1:0] cnt;

  // All outputs are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ASSERT;
      cnt        <= A_LOAD;
      resetn_out <= 1'b0;
      in_reset   <= 1'b1;
      req_ready  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      unique case (state)
        ST_ASSERT: begin
          if (cnt == '0) begin
            resetn_out <= 1'b1;
            in_reset   <= 1'b0;
            done_pulse <= 1'b1;
`ifdef BSC_RESET_PULSE_GEN_HOLDOFF_EN
            state      <= ST_HOLDOFF;
            cnt        <= H_LOAD;
            req_ready  <= 1'b0;
`else
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            state      <= ST_ASSERT;
            cnt        <= A_LOAD;
            resetn_out <= 1'b0;
            in_reset   <= 1'b1;
            req_ready  <= 1'b0;
          end
        end
        default: begin
          state      <= ST_ASSERT;
          cnt        <= A_LOAD;
          resetn_out <= 1'b0;
          in_reset   <= 1'b1;
          req_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`endif

// File: doc/bsc_reset_pulse_gen.md
BSC_RESET_PULSE_GEN -- requirements
Module: bsc_reset_pulse_gen

Interface
REQ-001 Parameter ASSERT_CYCLES, default 4: cycles resetn_out is held low per reset event; legal range is >=1.
REQ-002 Parameter HOLDOFF_CYCLES, default 2: cycles after release during which new requests are refused; legal range is >=1; used only when the holdoff feature is compiled in.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req_valid, input, 1 bit: request for a downstream reset pulse.
REQ-006 Port req_ready, output, 1 bit: block can accept a request this cycle.
REQ-007 Port resetn_out, output, 1 bit: registered active-low reset driving downstream resetn inputs.
REQ-008 Port in_reset, output, 1 bit: high whenever resetn_out is low.
REQ-009 Port done_pulse, output, 1 bit: one-cycle strobe marking release of resetn_out.

Function
REQ-010 The block SHALL implement the states ASSERT, HOLDOFF and IDLE.
REQ-011 ASSERT SHALL drive resetn_out=0, in_reset=1 and req_ready=0.
REQ-012 In ASSERT, a down-counter loaded with ASSERT_CYCLES-1 SHALL decrement each cycle; on the cycle it reads 0, the next state SHALL be HOLDOFF (feature on) or IDLE (feature off).
REQ-013 resetn_out SHALL be low for exactly ASSERT_CYCLES consecutive cycles per event, with no glitch or extra cycle.
REQ-014 HOLDOFF SHALL drive resetn_out=1 and req_ready=0, count HOLDOFF_CYCLES cycles, then enter IDLE.
REQ-015 IDLE SHALL drive resetn_out=1 and req_ready=1.
REQ-016 A request is accepted when req_valid=1 and req_ready=1 at edge N; resetn_out SHALL be 0 from cycle N+1.
REQ-017 req_valid while req_ready=0 SHALL be ignored, not queued.
REQ-018 req_ready SHALL be a function of the registered state only, with no combinational path from req_valid.
REQ-019 done_pulse SHALL be 1 in exactly the first cycle resetn_out returns to 1 after each event, and 0 otherwise.
REQ-020 The counter width SHALL be $clog2 of max(ASSERT_CYCLES, HOLDOFF_CYCLES)+1 bits, and the counter SHALL never wrap.

Reset
REQ-021 While reset=1 the block SHALL hold state ASSERT and keep the counter at its load value, driving resetn_out=0, in_reset=1, req_ready=0 and done_pulse=0.
REQ-022 After the last cycle with reset=1, resetn_out SHALL stay low for exactly ASSERT_CYCLES further cycles.
REQ-023 reset asserted in any state, including mid-ASSERT or mid-HOLDOFF, SHALL restart the full ASSERT count from its load value.
REQ-024 reset asserted in the same cycle as an accepted request SHALL take priority; the request is discarded.

Configuration
REQ-025 Macro BSC_RESET_PULSE_GEN_HOLDOFF_EN, when defined, SHALL compile in the HOLDOFF state and the HOLDOFF_CYCLES parameter usage.
REQ-026 With BSC_RESET_PULSE_GEN_HOLDOFF_EN undefined, ASSERT SHALL go directly to IDLE, and req_ready SHALL be 1 in the same cycle done_pulse is 1.

Structure
REQ-027 The state enum type and the state encoding constants SHALL live in the shared bluespec package.
REQ-028 The counter width function SHALL also live in the shared bluespec package.
REQ-029 The block SHALL be a single module with no sub-modules.
REQ-030 The block SHALL be amalgamation-safe, and its testbench SHALL be guarded by __BSC_TESTBENCH__.

Verification (ASSERT_CYCLES=4, HOLDOFF_CYCLES=2 unless stated)
REQ-031 Power-up: reset=1 for 3 cycles, then 0 -> resetn_out low for 4 more cycles; done_pulse=1 on cycle 5 after the reset release; req_ready=1 two cycles later (holdoff on).
REQ-032 Request: req_valid=1 for one cycle in IDLE at edge N -> resetn_out=0 on cycles N+1..N+4, resetn_out=1 on cycle N+5, done_pulse=1 on cycle N+5.
REQ-033 Ignored request: req_valid held 1 through ASSERT and HOLDOFF -> exactly one extra event, accepted on the first IDLE cycle, and no event queued from earlier.
REQ-034 Reset mid-assert: reset pulse at count 1 of 4 -> resetn_out low for 4 full cycles after the reset pulse; done_pulse asserted once only.
REQ-035 Macro undefined: request, release, then req_valid=1 on the done_pulse cycle -> accepted; resetn_out returns low on the next cycle.
REQ-036 ASSERT_CYCLES=1: request -> exactly one low cycle, and done_pulse on the following cycle.
